ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares one single-port, byte-addressed, little-endian 32-bit memory between the instruction fetch
//  port (I) and the load/store port (D) of the rv32i core. Grants at most one access per cycle.
//  Memory read data arrives one cycle after the access; the arbiter routes it back to the owning port.
//  Includes a starvation guard so a load/store-heavy loop cannot stall fetch indefinitely.
// PARAMETERS
//  ADDR_WIDTH  17  byte-address width of the shared memory
//  STARVE_MAX  4   consecutive I-port losses before I gets forced priority (1..15)
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  i_req      in   1   fetch request, held with i_addr until i_gnt
//  i_addr     in   AW  fetch byte address
//  i_gnt      out  1   fetch accepted this cycle (combinational)
//  i_rvalid   out  1   i_rdata valid (one cycle after i_gnt)
//  i_rdata    out  32  fetched instruction word
//  d_req      in   1   load/store request, held with its fields until d_gnt
//  d_we       in   1   1 = store, 0 = load
//  d_be       in   4   store byte enables; bit n = byte addr+n
//  d_addr     in   AW  load/store byte address
//  d_wdata    in   32  store data, byte n in bits [8n+7:8n]
//  d_gnt      out  1   load/store accepted this cycle (combinational)
//  d_rvalid   out  1   load response valid (one cycle after d_gnt, loads and misaligned only)
//  d_rdata    out  32  load data
//  d_err      out  1   qualifies d_rvalid: access was misaligned, no memory access performed
//  mem_en     out  1   memory access strobe
//  mem_we     out  1   memory write
//  mem_be     out  4   memory byte enables
//  mem_addr   out  AW  word-aligned byte address to memory
//  mem_wdata  out  32  memory write data
//  mem_rdata  in   32  memory read data, valid the cycle after mem_en & !mem_we
// BEHAVIOUR
//  - Reset: i_rvalid, d_rvalid, d_err, mem_en, mem_we = 0; mem_be = 0; starve_cnt = 0; owner = NONE.
//    A read in flight when rst is asserted is dropped: no rvalid is issued after reset.
//  - Arbitration, each cycle:
//    - only one port requesting: that port wins;
//    - both requesting: D wins unless starve_cnt == STARVE_MAX, in which case I wins.
//  - Starve counter:
//    - starve_cnt++ (saturating at STARVE_MAX) when i_req & !i_gnt;
//    - cleared whenever i_gnt = 1 or i_req = 0.
//  - Access forwarding: the granted port's fields go to mem_* combinationally, with mem_en = gnt & aligned.
//    The I port always uses mem_we = 0 and mem_be = 4'hF.
//  - Alignment:
//    - i_addr[1:0] != 0 is not checked; the low bits are forced to 0 on mem_addr;
//    - D accesses with d_addr[1:0] != 0 are granted with mem_en = 0 and answered next cycle with
//      d_rvalid = 1, d_err = 1, d_rdata = 0, whether load or store.
//  - Response: a registered owner tag (NONE/I/D) is set on a granted read, otherwise NONE.
//    - Next cycle, i_rvalid = (owner == I) and d_rvalid = (owner == D).
//    - rdata = mem_rdata for the owner, 0 for the other port.
//  - Aligned stores: d_gnt is the only acknowledgement; no d_rvalid is issued.
//  - Throughput: back-to-back grants every cycle; a grant may coincide with the previous response.
//  - Latency: request to grant 0 cycles when it wins; grant to rvalid exactly 1 cycle.
// STRUCTURE
//  - Shared package ram_arb_pkg: owner_t enum {OWN_NONE, OWN_I, OWN_D}; BE_WORD = 4'hF.
//  - No sub-module. Arbitration logic is combinational; owner, err flag and starve_cnt are registers.
//  - Bench memory model: a registered variant of ram_inst with 1-cycle read and byte-enabled writes.
// TESTING
//  1. Only I: i_req, i_addr=0x0 then 0x4 back-to-back -> i_gnt both cycles; i_rvalid in cycles 2,3
//     with image words 0 and 1.
//  2. Both requesting every cycle, STARVE_MAX=4 -> D granted 4 cycles, I granted cycle 5, D resumes;
//     pattern repeats every 5 cycles.
//  3. Store d_addr=0x100, d_be=4'b0011, d_wdata=0xAABBCCDD over 0x11223344, then load 0x100
//     -> d_rvalid once, d_rdata=0x1122CCDD, no rvalid for the store.
//  4. Load d_addr=0x102 -> d_gnt=1, mem_en=0; next cycle d_rvalid=1, d_err=1, d_rdata=0;
//     memory unchanged.
//  5. rst asserted the cycle after an I read grant -> i_rvalid stays 0; all outputs at reset values;
//     starve_cnt=0.
//  6. I requesting alone with i_addr=0x13 -> mem_addr=0x10, i_rdata = word at 0x10.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Fetch port, load/store port and shared-memory bus seen by the arbiter.
interface ram_arb_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [3:0]            d_be;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [31:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;
  logic                  d_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port memory shared between fetch (I) and load/store (D); D has priority
// except when fetch has lost STARVE_MAX arbitrations in a row.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  ram_arb_if.slave bus
);

  localparam int               CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == STARVE_LIM) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]      r_starve_cnt;
  owner_t                r_owner_p1;
  logic                  r_err_p1;

  logic                  w_starved;
  logic                  w_i_gnt;
  logic                  w_d_gnt;
  logic                  w_d_aligned;
  logic                  w_d_mem;
  logic                  w_i_own;
  logic                  w_d_own;
  logic [ADDR_WIDTH-1:0] w_addr_sel;
  owner_t                w_owner_nxt;

  // Stage p0: combinational arbitration and forwarding to memory
  assign w_starved   = (r_starve_cnt == STARVE_LIM);
  assign w_i_gnt     = !rst && bus.i_req && (!bus.d_req || w_starved);
  assign w_d_gnt     = !rst && bus.d_req && !w_i_gnt;
  assign w_d_aligned = word_aligned(bus.d_addr[1:0]);
  assign w_d_mem     = w_d_gnt && w_d_aligned;

  assign bus.i_gnt = w_i_gnt;
  assign bus.d_gnt = w_d_gnt;

  assign w_addr_sel    = w_i_gnt ? bus.i_addr : (w_d_mem ? bus.d_addr : '0);
  assign bus.mem_en    = w_i_gnt || w_d_mem;
  assign bus.mem_we    = w_d_mem && bus.d_we;
  assign bus.mem_be    = w_i_gnt ? BE_WORD : (w_d_mem ? bus.d_be : 4'h0);
  assign bus.mem_addr  = w_addr_sel & ~ADDR_WIDTH'(3);
  assign bus.mem_wdata = (w_d_mem && bus.d_we) ? bus.d_wdata : 32'h0;

  // Misaligned D accesses answer with an error regardless of direction
  always_comb begin
    w_owner_nxt = OWN_NONE;
    if (w_i_gnt) begin
      w_owner_nxt = OWN_I;
    end else if (w_d_gnt && (!w_d_aligned || !bus.d_we)) begin
      w_owner_nxt = OWN_D;
    end
  end

  // Stage p1: response ownership and starvation tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_p1   <= OWN_NONE;
      r_err_p1     <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_owner_p1 <= w_owner_nxt;
      r_err_p1   <= w_d_gnt && !w_d_aligned;
      if (!bus.i_req || w_i_gnt) begin
        r_starve_cnt <= '0;
      end else begin
        r_starve_cnt <= sat_inc(r_starve_cnt);
      end
    end
  end

  // An in-flight read is dropped while reset is held
  assign w_i_own = !rst && (r_owner_p1 == OWN_I);
  assign w_d_own = !rst && (r_owner_p1 == OWN_D);

  assign bus.i_rvalid = w_i_own;
  assign bus.i_rdata  = w_i_own ? bus.mem_rdata : 32'h0;
  assign bus.d_rvalid = w_d_own;
  assign bus.d_err    = w_d_own && r_err_p1;
  assign bus.d_rdata  = (w_d_own && !r_err_p1) ? bus.mem_rdata : 32'h0;

endmodule
